lector_displays: RTL and testbench

- Receive-side counterpart of the BCD-to-7-segment decoder.
- Samples an externally driven, time-multiplexed common-anode display bus: active-low anode strobes plus active-low segments a..g, with segmento[0]=a.
- Recovers the 4-bit code shown on each digit and flags blank and unrecognised patterns.
- Sits between the board display header and the internal register bank. Used for loopback self-test and for capturing a slave board's display.

---
 rtl/pkg_displays.sv | 19 +
 rtl/patron_a_codigo.sv | 33 +++
 rtl/lector_displays.sv | 180 ++++++++++++++++++
 tb/tb_lector_displays.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pkg_displays.sv
// pkg_displays: active-low 7-segment pattern constants and code type shared by the display reader
package pkg_displays;
    typedef logic [3:0] codigo_t;
    localparam logic [6:0] PATRON_0     = 7'b1000000;
    localparam logic [6:0] PATRON_1     = 7'b1111001;
    localparam logic [6:0] PATRON_2     = 7'b0100100;
    localparam logic [6:0] PATRON_3     = 7'b0110000;
    localparam logic [6:0] PATRON_4     = 7'b0011001;
    localparam logic [6:0] PATRON_5     = 7'b0010010;
    localparam logic [6:0] PATRON_6     = 7'b0000010;
    localparam logic [6:0] PATRON_7     = 7'b1111000;
    localparam logic [6:0] PATRON_8     = 7'b0000000;
    localparam logic [6:0] PATRON_9     = 7'b0010000;
    localparam logic [6:0] PATRON_A     = 7'b0001000;
    localparam logic [6:0] PATRON_C     = 7'b1000110;
    localparam logic [6:0] PATRON_E     = 7'b0000110;
    localparam logic [6:0] PATRON_F     = 7'b0001110;
    localparam logic [6:0] PATRON_VACIO = 7'b1111111;
endpackage

// File: rtl/patron_a_codigo.sv
// patron_a_codigo: maps an active-low segment pattern (bit 0 = a) back to its 4-bit code
module patron_a_codigo
    import pkg_displays::*;
(
    input  logic [6:0] segmento,
    output codigo_t    codigo,
    output logic       vacio,
    output logic       invalido
);
    always_comb begin
        codigo   = 4'h0;
        vacio    = 1'b0;
        invalido = 1'b0;
        case (segmento)
            PATRON_0:     codigo = 4'h0;
            PATRON_1:     codigo = 4'h1;
            PATRON_2:     codigo = 4'h2;
            PATRON_3:     codigo = 4'h3;
            PATRON_4:     codigo = 4'h4;
            PATRON_5:     codigo = 4'h5;
            PATRON_6:     codigo = 4'h6;
            PATRON_7:     codigo = 4'h7;
            PATRON_8:     codigo = 4'h8;
            PATRON_9:     codigo = 4'h9;
            PATRON_A:     codigo = 4'hA;
            PATRON_C:     codigo = 4'hC;
            PATRON_E:     codigo = 4'hE;
            PATRON_F:     codigo = 4'hF;
            PATRON_VACIO: vacio  = 1'b1;
            default:      invalido = 1'b1;
        endcase
    end
endmodule

// File: rtl/lector_displays.sv
// lector_displays: samples a multiplexed common-anode display bus and recovers per-digit codes
module lector_displays
    import pkg_displays::*;
#(
    parameter int N_DIG   = 4,
    parameter int GUARDA  = 4,
    parameter int ESTABLE = 8,
    parameter int TIMEOUT = 200000,
    localparam int IW     = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_DIG-1:0]   anodo_n,
    input  logic [6:0]         segmento,
    output logic [4*N_DIG-1:0] digitos,
    output logic [N_DIG-1:0]   vacio,
    output logic [N_DIG-1:0]   invalido,
    output logic [N_DIG-1:0]   vigente,
    output logic               nuevo,
    output logic [IW-1:0]      indice
);
    localparam int GW = $clog2(GUARDA + 1);
    localparam int EW = $clog2(ESTABLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {ST_ESPERA, ST_GUARDA, ST_MUESTREO, ST_COMMIT, ST_RETENCION} estado_t;

    estado_t            r_estado, w_estado_sig;
    logic [N_DIG-1:0]   r_an_s1, r_an_s2;
    logic [6:0]         r_seg_s1, r_seg_s2;
    logic [IW-1:0]      r_idx, w_idx_sig, w_idx;
    logic [GW-1:0]      r_guard, w_guard_sig;
    logic [EW-1:0]      r_est, w_est_sig;
    logic [6:0]         r_cand, w_cand_sig;
    logic [N_DIG-1:0]   w_act;
    logic               w_valido, w_cambio, w_commit, w_dif;
    codigo_t            w_cod;
    logic               w_vac, w_inv;
    logic [4*N_DIG-1:0] r_digitos;
    logic [N_DIG-1:0]   r_vacio, r_invalido, r_vigente;
    logic               r_nuevo;
    logic [IW-1:0]      r_indice;
    logic [TW-1:0]      r_tmr [N_DIG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_s1  <= '1;
            r_an_s2  <= '1;
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
        end else begin
            r_an_s1  <= anodo_n;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= segmento;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // a strobe is only valid when exactly one anode is driven low
    assign w_act    = ~r_an_s2;
    assign w_valido = (w_act != '0) && ((w_act & (w_act - 1'b1)) == '0);
    assign w_cambio = w_idx != r_idx;
    assign w_commit = r_estado == ST_COMMIT;

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < N_DIG; k++)
            if (w_act[k]) w_idx = IW'(k);
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_idx_sig    = r_idx;
        w_guard_sig  = r_guard;
        w_cand_sig   = r_cand;
        w_est_sig    = r_est;
        case (r_estado)
            ST_ESPERA:
                if (w_valido) begin
                    w_estado_sig = ST_GUARDA;
                    w_idx_sig    = w_idx;
                    w_guard_sig  = '0;
                end
            ST_GUARDA:
                if (!w_valido) w_estado_sig = ST_ESPERA;
                else if (w_cambio) begin
                    w_idx_sig   = w_idx;
                    w_guard_sig = '0;
                end else if (r_guard == GW'(GUARDA - 1)) begin
                    w_estado_sig = ST_MUESTREO;
                    w_cand_sig   = r_seg_s2;
                    w_est_sig    = EW'(1);
                end else w_guard_sig = r_guard + 1'b1;
            ST_MUESTREO:
                if (!w_valido) w_estado_sig = ST_ESPERA;
                else if (w_cambio) begin
                    w_estado_sig = ST_GUARDA;
                    w_idx_sig    = w_idx;
                    w_guard_sig  = '0;
                end else if (r_seg_s2 != r_cand) begin
                    w_cand_sig = r_seg_s2;
                    w_est_sig  = EW'(1);
                end else begin
                    w_est_sig    = r_est + 1'b1;
                    w_estado_sig = (r_est == EW'(ESTABLE - 1)) ? ST_COMMIT : ST_MUESTREO;
                end
            ST_COMMIT: w_estado_sig = ST_RETENCION;
            default:
                if (!w_valido) w_estado_sig = ST_ESPERA;
                else if (w_cambio) begin
                    w_estado_sig = ST_GUARDA;
                    w_idx_sig    = w_idx;
                    w_guard_sig  = '0;
                end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= ST_ESPERA;
            r_idx    <= '0;
            r_guard  <= '0;
            r_est    <= '0;
            r_cand   <= '1;
        end else begin
            r_estado <= w_estado_sig;
            r_idx    <= w_idx_sig;
            r_guard  <= w_guard_sig;
            r_est    <= w_est_sig;
            r_cand   <= w_cand_sig;
        end
    end

    patron_a_codigo u_dec (
        .segmento (r_cand),
        .codigo   (w_cod),
        .vacio    (w_vac),
        .invalido (w_inv)
    );

    assign w_dif = {w_cod, w_vac, w_inv} != {r_digitos[r_idx*4 +: 4], r_vacio[r_idx], r_invalido[r_idx]};

    // a commit reloads its digit's timer, so it wins over a same-cycle timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digitos  <= '0;
            r_vacio    <= '1;
            r_invalido <= '0;
            r_vigente  <= '0;
            r_nuevo    <= 1'b0;
            r_indice   <= '0;
            for (int k = 0; k < N_DIG; k++) r_tmr[k] <= '0;
        end else begin
            r_nuevo <= 1'b0;
            if (w_commit) begin
                r_digitos[r_idx*4 +: 4] <= w_cod;
                r_vacio[r_idx]          <= w_vac;
                r_invalido[r_idx]       <= w_inv;
                r_indice                <= r_idx;
                r_nuevo                 <= w_dif;
            end
            for (int k = 0; k < N_DIG; k++) begin
                if (w_commit && r_idx == IW'(k)) begin
                    r_tmr[k]     <= '0;
                    r_vigente[k] <= 1'b1;
                end else if (r_tmr[k] != TW'(TIMEOUT)) begin
                    r_tmr[k] <= r_tmr[k] + 1'b1;
                    if (r_tmr[k] == TW'(TIMEOUT - 1)) r_vigente[k] <= 1'b0;
                end
            end
        end
    end

    assign digitos  = r_digitos;
    assign vacio    = r_vacio;
    assign invalido = r_invalido;
    assign vigente  = r_vigente;
    assign nuevo    = r_nuevo;
    assign indice   = r_indice;
endmodule

// File: tb/tb_lector_displays.sv
// tb_lector_displays: scoreboard bench for the display reader with a shortened timeout
module tb_lector_displays;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  anodo_n = 4'hF;
    logic [6:0]  segmento = 7'h7F;
    logic [15:0] digitos;
    logic [3:0]  vacio, invalido, vigente;
    logic        nuevo;
    logic [1:0]  indice;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] q_exp[$];
    logic [7:0] e_mon;
    logic [3:0] m_cod [4];
    logic       m_vac [4];
    logic       m_inv [4];

    always #5 clk = ~clk;

    lector_displays #(.N_DIG(4), .GUARDA(4), .ESTABLE(8), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .anodo_n  (anodo_n),
        .segmento (segmento),
        .digitos  (digitos),
        .vacio    (vacio),
        .invalido (invalido),
        .vigente  (vigente),
        .nuevo    (nuevo),
        .indice   (indice)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {code, vacio, invalido}
    function automatic logic [5:0] ref_dec(input logic [6:0] p);
        case (p)
            7'b1000000: return {4'h0, 2'b00};
            7'b1111001: return {4'h1, 2'b00};
            7'b0100100: return {4'h2, 2'b00};
            7'b0110000: return {4'h3, 2'b00};
            7'b0011001: return {4'h4, 2'b00};
            7'b0010010: return {4'h5, 2'b00};
            7'b0000010: return {4'h6, 2'b00};
            7'b1111000: return {4'h7, 2'b00};
            7'b0000000: return {4'h8, 2'b00};
            7'b0010000: return {4'h9, 2'b00};
            7'b0001000: return {4'hA, 2'b00};
            7'b1000110: return {4'hC, 2'b00};
            7'b0000110: return {4'hE, 2'b00};
            7'b0001110: return {4'hF, 2'b00};
            7'b1111111: return {4'h0, 2'b10};
            default:    return {4'h0, 2'b01};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cod[i] = 4'h0;
            m_vac[i] = 1'b1;
            m_inv[i] = 1'b0;
        end
        q_exp.delete();
    endtask

    task automatic expect_show(input int d, input logic [6:0] p);
        logic [5:0] r;
        r = ref_dec(p);
        if (r != {m_cod[d], m_vac[d], m_inv[d]}) begin
            q_exp.push_back({2'(d), r});
            {m_cod[d], m_vac[d], m_inv[d]} = r;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        anodo_n  = an;
        segmento = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << d);
        if (n >= 16) expect_show(d, p);
        drive(an, p, n);
        drive(4'hF, 7'h7F, 2);
    endtask

    always @(negedge clk) begin
        if (reset_n && nuevo) begin
            if (q_exp.size() == 0) check("nuevo_unexpected", 32'(nuevo), 32'd0);
            else begin
                e_mon = q_exp.pop_front();
                check("commit", {indice, digitos[indice*4 +: 4], vacio[indice], invalido[indice]}, e_mon);
            end
        end
    end

    initial begin
        model_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("rst_digitos", digitos, 0);
        check("rst_vacio", vacio, 4'hF);
        check("rst_invalido", invalido, 0);
        check("rst_vigente", vigente, 0);
        check("rst_nuevo", nuevo, 0);
        check("rst_indice", indice, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(4'hF, 7'h7F, 2 * TO + 50);
        check("idle_vigente", vigente, 0);
        check("idle_digitos", digitos, 0);

        expect_show(0, 7'b0100100);
        anodo_n  = 4'b1110;
        segmento = 7'b0100100;
        repeat (15) @(negedge clk);
        check("lat_early_digitos", digitos, 0);
        check("lat_early_nuevo", nuevo, 0);
        @(negedge clk);
        check("lat_digitos", digitos[3:0], 4'h2);
        check("lat_nuevo", nuevo, 1);
        check("lat_indice", indice, 0);
        check("lat_vigente", vigente[0], 1);
        @(posedge clk);
        #1;
        drive(4'b1110, 7'b0100100, 3);
        drive(4'hF, 7'h7F, 2);

        show(0, 7'b1111001, 30);
        show(1, 7'b0000000, 30);
        show(2, 7'b0001110, 30);
        show(3, 7'b1111111, 30);
        check("scan_digitos", digitos, 16'h0F81);
        check("scan_vacio", vacio, 4'b1000);
        check("scan_vigente", vigente, 4'hF);
        check("scan_pending", q_exp.size(), 0);

        expect_show(1, 7'b0010010);
        drive(4'b1101, 7'b0111111, 3);
        drive(4'b1101, 7'b0010010, 25);
        drive(4'hF, 7'h7F, 2);
        check("ghost_digitos", digitos[7:4], 4'h5);
        check("ghost_indice", indice, 1);
        for (int i = 0; i < 8; i++) drive(4'b1101, (i % 2) ? 7'b1111000 : 7'b0000010, 5);
        drive(4'hF, 7'h7F, 2);
        check("toggle_digitos", digitos[7:4], 4'h5);
        check("toggle_pending", q_exp.size(), 0);

        show(2, 7'b0101010, 25);
        check("inv_flag", invalido[2], 1);
        check("inv_digitos", digitos[11:8], 0);
        show(2, 7'b0101010, 25);
        check("inv_pending", q_exp.size(), 0);

        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        expect_show(0, 7'b1111000);
        anodo_n  = 4'b1110;
        segmento = 7'b1111000;
        repeat (16) @(negedge clk);
        check("to_commit_digitos", digitos[3:0], 4'h7);
        check("to_commit_vigente", vigente[0], 1);
        anodo_n  = 4'hF;
        segmento = 7'h7F;
        repeat (TO - 1) @(negedge clk);
        check("to_before_vigente", vigente[0], 1);
        @(negedge clk);
        check("to_after_vigente", vigente[0], 0);
        check("to_after_digitos", digitos, 16'h0007);
        check("to_after_vacio", vacio, 4'b1110);

        @(posedge clk);
        #1;
        drive(4'b1011, 7'b0011001, 10);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_digitos", digitos, 0);
        check("mid_rst_vacio", vacio, 4'hF);
        check("mid_rst_vigente", vigente, 0);
        check("mid_rst_indice", indice, 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        expect_show(2, 7'b0011001);
        drive(4'b1011, 7'b0011001, 25);
        drive(4'hF, 7'h7F, 2);
        check("post_rst_digitos", digitos, 16'h0400);
        check("post_rst_vigente", vigente, 4'b0100);
        check("post_rst_indice", indice, 2);
        check("final_pending", q_exp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
